// File: rtl/memory_loader.sv
// Host-driven loader that turns a command/payload word stream into RAM write cycles on
// the IM/DM load ports. Define LOADER_CHECKSUM_EN to require a trailing checksum word per region.
module memory_loader #(
  parameter int ADDRESS_WIDTH = 11,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     host_valid,
  input  logic [DATA_WIDTH-1:0]    host_data,
  output logic                     host_ready,
  output logic                     loading,
  output logic                     im_cen_load,
  output logic                     im_wen_load,
  output logic                     im_oen_load,
  output logic [ADDRESS_WIDTH-1:0] im_addr_load,
  output logic [DATA_WIDTH-1:0]    im_datain_load,
  output logic                     dm_cen_load,
  output logic                     dm_wen_load,
  output logic                     dm_oen_load,
  output logic [ADDRESS_WIDTH-1:0] dm_addr_load,
  output logic [DATA_WIDTH-1:0]    dm_datain_load,
  output logic                     load_done,
  output logic                     err
);

  localparam logic [1:0] OP_WRITE_IM = 2'b00;
  localparam logic [1:0] OP_WRITE_DM = 2'b01;
  localparam logic [1:0] OP_DONE     = 2'b10;

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {CMD, DATA, CHK, FIN} state_t;
  logic [DATA_WIDTH-1:0] acc;
`else
  typedef enum logic [1:0] {CMD, DATA, FIN} state_t;
`endif

  state_t                   state;
  logic                     tgt_dm;
  logic [ADDRESS_WIDTH-1:0] cur_addr;
  logic [ADDRESS_WIDTH-1:0] count;
  logic                     accept;
  logic [1:0]               opcode;

  assign accept = host_valid && host_ready;
  assign opcode = host_data[31:30];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= CMD;
      host_ready     <= 1'b0;
      loading        <= 1'b1;
      load_done      <= 1'b0;
      err            <= 1'b0;
      tgt_dm         <= 1'b0;
      cur_addr       <= '0;
      count          <= '0;
      im_cen_load    <= 1'b1;
      im_wen_load    <= 1'b1;
      im_oen_load    <= 1'b1;
      im_addr_load   <= '0;
      im_datain_load <= '0;
      dm_cen_load    <= 1'b1;
      dm_wen_load    <= 1'b1;
      dm_oen_load    <= 1'b1;
      dm_addr_load   <= '0;
      dm_datain_load <= '0;
`ifdef LOADER_CHECKSUM_EN
      acc            <= '0;
`endif
    end else begin
      // Strobes are single-cycle pulses; they fall back to idle unless a word lands this edge.
      im_cen_load <= 1'b1;
      im_wen_load <= 1'b1;
      im_oen_load <= 1'b1;
      dm_cen_load <= 1'b1;
      dm_wen_load <= 1'b1;
      dm_oen_load <= 1'b1;

      case (state)
        CMD: begin
          host_ready <= 1'b1;
          if (accept) begin
            case (opcode)
              OP_WRITE_IM, OP_WRITE_DM: begin
                tgt_dm   <= (opcode == OP_WRITE_DM);
                cur_addr <= host_data[ADDRESS_WIDTH-1:0];
                count    <= host_data[16 +: ADDRESS_WIDTH];
                state    <= DATA;
`ifdef LOADER_CHECKSUM_EN
                acc      <= '0;
`endif
              end
              OP_DONE: begin
                state      <= FIN;
                host_ready <= 1'b0;
                loading    <= 1'b0;
                load_done  <= 1'b1;
              end
              default: err <= 1'b1;
            endcase
          end
        end

        DATA: begin
          host_ready <= 1'b1;
          if (accept) begin
            if (tgt_dm) begin
              dm_cen_load    <= 1'b0;
              dm_wen_load    <= 1'b0;
              dm_addr_load   <= cur_addr;
              dm_datain_load <= host_data;
            end else begin
              im_cen_load    <= 1'b0;
              im_wen_load    <= 1'b0;
              im_addr_load   <= cur_addr;
              im_datain_load <= host_data;
            end
            cur_addr <= cur_addr + ADDRESS_WIDTH'(1);
            count    <= count - ADDRESS_WIDTH'(1);
`ifdef LOADER_CHECKSUM_EN
            acc      <= acc + host_data;
            if (count == '0) state <= CHK;
`else
            if (count == '0) state <= CMD;
`endif
          end
        end

`ifdef LOADER_CHECKSUM_EN
        CHK: begin
          host_ready <= 1'b1;
          if (accept) begin
            if (host_data != acc) err <= 1'b1;
            state <= CMD;
          end
        end
`endif

        FIN: begin
          host_ready <= 1'b0;
        end

        default: state <= CMD;
      endcase
    end
  end

endmodule
